// File: rtl/i2c_pkg.sv
// Shared types for the I2C target receiver: FSM state encoding and address width.
package i2c_pkg;

   localparam int I2C_ADDR_W = 7;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      DATA,
      DATA_ACK,
      IGNORE
   } state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes raw SCL/SDA into clk_div, adds one delay flop, and decodes
// bus events (SCL edges, START, STOP) from the synchronized pair.
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_div,
   input  logic reset,
   input  logic scl_in,
   input  logic sda_in,
   output logic scl_s,
   output logic sda_s,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det_raw
);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_d;
   logic                   sda_d;

   // Flops reset to 1 (idle bus) so releasing reset never fakes an edge.
   always_ff @(posedge clk_div or posedge reset) begin
      if (reset) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
         scl_d    <= scl_sync[SYNC_STAGES-1];
         sda_d    <= sda_sync[SYNC_STAGES-1];
      end
   end

   assign scl_s        = scl_sync[SYNC_STAGES-1];
   assign sda_s        = sda_sync[SYNC_STAGES-1];
   assign scl_rise     = scl_s & ~scl_d;
   assign scl_fall     = ~scl_s & scl_d;
   // SDA may only move while SCL is stably high for START/STOP.
   assign start_det    = scl_s & scl_d & sda_d & ~sda_s;
   assign stop_det_raw = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: matches a 7-bit address, ACKs address and data bytes
// via an open-drain enable, and strobes each received byte to the fabric.
module i2c_target_rx
   import i2c_pkg::*;
#(
   parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h2B,
   parameter int                    SYNC_STAGES = 2
) (
   input  logic       clk_div,
   input  logic       reset,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       addr_match,
   output logic       busy,
   output logic       stop_det
);

   logic       scl_s;
   logic       sda_s;
   logic       scl_rise;
   logic       scl_fall;
   logic       start_det;
   logic       stop_det_raw;
   logic       drive_edge;
   state_t     state;
   logic [2:0] bit_cnt;
   logic       byte_done;
   logic       ack_phase;
   logic [7:0] shift_reg;

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
      .clk_div      (clk_div),
      .reset        (reset),
      .scl_in       (scl_in),
      .sda_in       (sda_in),
      .scl_s        (scl_s),
      .sda_s        (sda_s),
      .scl_rise     (scl_rise),
      .scl_fall     (scl_fall),
      .start_det    (start_det),
      .stop_det_raw (stop_det_raw)
   );

   // sda_oe only ever changes while SCL is low.
   assign drive_edge = scl_fall & ~scl_s;

   // START/STOP override everything; otherwise each state reacts to SCL edges.
   always_ff @(posedge clk_div or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         sda_oe     <= 1'b0;
         rx_data    <= 8'h00;
         rx_valid   <= 1'b0;
         addr_match <= 1'b0;
         busy       <= 1'b0;
         stop_det   <= 1'b0;
         bit_cnt    <= 3'd0;
         byte_done  <= 1'b0;
         ack_phase  <= 1'b0;
         shift_reg  <= 8'h00;
      end else begin
         rx_valid <= 1'b0;
         stop_det <= 1'b0;
         if (start_det) begin
            busy       <= 1'b1;
            addr_match <= 1'b0;
            sda_oe     <= 1'b0;
            bit_cnt    <= 3'd0;
            byte_done  <= 1'b0;
            ack_phase  <= 1'b0;
            state      <= ADDR;
         end else if (stop_det_raw) begin
            stop_det   <= 1'b1;
            busy       <= 1'b0;
            addr_match <= 1'b0;
            sda_oe     <= 1'b0;
            bit_cnt    <= 3'd0;
            byte_done  <= 1'b0;
            ack_phase  <= 1'b0;
            state      <= IDLE;
         end else begin
            case (state)
               ADDR: begin
                  if (scl_rise) begin
                     shift_reg <= {shift_reg[6:0], sda_s};
                     if (bit_cnt == 3'd7) begin
                        bit_cnt <= 3'd0;
                        state   <= ADDR_ACK;
                     end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                     end
                  end
               end
               ADDR_ACK: begin
                  if (drive_edge) begin
                     if (!ack_phase) begin
                        if (shift_reg[7:1] == SLAVE_ADDR && !shift_reg[0]) begin
                           sda_oe     <= 1'b1;
                           addr_match <= 1'b1;
                           ack_phase  <= 1'b1;
                        end else begin
                           sda_oe <= 1'b0;
                           state  <= IGNORE;
                        end
                     end else begin
                        sda_oe    <= 1'b0;
                        ack_phase <= 1'b0;
                        state     <= DATA;
                     end
                  end
               end
               DATA: begin
                  if (byte_done) begin
                     rx_data   <= shift_reg;
                     rx_valid  <= 1'b1;
                     byte_done <= 1'b0;
                     state     <= DATA_ACK;
                  end else if (scl_rise) begin
                     shift_reg <= {shift_reg[6:0], sda_s};
                     if (bit_cnt == 3'd7) begin
                        bit_cnt   <= 3'd0;
                        byte_done <= 1'b1;
                     end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                     end
                  end
               end
               DATA_ACK: begin
                  if (drive_edge) begin
                     if (!ack_phase) begin
                        sda_oe    <= 1'b1;
                        ack_phase <= 1'b1;
                     end else begin
                        sda_oe    <= 1'b0;
                        ack_phase <= 1'b0;
                        state     <= DATA;
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule
